// File: rtl/keccak_pkg.sv
// ----------------------------------------------------------------------------
// keccak_pkg
// Shared definitions for the slice-serial Keccak theta datapath.
//   SLICE_W   : bits per slice (5x5 plane, bit index 5*y + x)
//   NCOL      : number of columns (x) in a slice
//   state_t   : lane sequencing states of theta_lane_engine
//   bit_idx   : position of (x, y) inside a slice
//   theta_mix : applies theta to one slice given its own column parity and
//               the column parity of the preceding slice
// ----------------------------------------------------------------------------
package keccak_pkg;

   localparam int SLICE_W = 25;
   localparam int NCOL    = 5;

   typedef enum logic [1:0] {
      S_FIRST,
      S_STREAM,
      S_FLUSH
   } state_t;

   function automatic int bit_idx(input int x, input int y);
      return NCOL * y + x;
   endfunction

   // D[x] = C[x-1][z] ^ C[x+1][z-1]; a bypassed lane forces D to zero.
   function automatic logic [SLICE_W-1:0] theta_mix(
      input logic [SLICE_W-1:0] slice,
      input logic [NCOL-1:0]    c_cur,
      input logic [NCOL-1:0]    c_prev,
      input logic               byp
   );
      logic [NCOL-1:0]    d;
      logic [SLICE_W-1:0] r;
      d = '0;
      r = slice;
      for (int x = 0; x < NCOL; x++) begin
         d[3'(x)] = byp ? 1'b0 : (c_cur[3'((x + 4) % NCOL)] ^ c_prev[3'((x + 1) % NCOL)]);
      end
      for (int y = 0; y < NCOL; y++) begin
         for (int x = 0; x < NCOL; x++) begin
            r[5'(bit_idx(x, y))] = slice[5'(bit_idx(x, y))] ^ d[3'(x)];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/slice_parity.sv
// ----------------------------------------------------------------------------
// slice_parity
// Column parity of one 25-bit slice: par_o[x] = XOR over y of bit(5*y + x).
// Ports:
//   slice_i : input slice
//   par_o   : 5-bit column parity vector C[.]
// ----------------------------------------------------------------------------
module slice_parity
   import keccak_pkg::*;
(
   input  logic [SLICE_W-1:0] slice_i,
   output logic [NCOL-1:0]    par_o
);

   always_comb begin
      // NOTE: par_o gets a full default before the loop so no path leaves it
      // unassigned, which would otherwise infer a latch.
      par_o = '0;
      for (int x = 0; x < NCOL; x++) begin
         for (int y = 0; y < NCOL; y++) begin
            par_o[3'(x)] = par_o[3'(x)] ^ slice_i[5'(bit_idx(x, y))];
         end
      end
   end

endmodule

// File: rtl/theta_lane_engine.sv
// ----------------------------------------------------------------------------
// theta_lane_engine
// Slice-serial Keccak theta step. Slices of one lane arrive in order
// z = 0..LANE_W-1 and leave theta-mixed in order z = 1..LANE_W-1, then 0.
// Slice 0 is held back because its mix needs the parity of slice LANE_W-1.
// A lane whose slice 0 arrives with bypass set passes through unmodified.
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-low reset
//   clr         : synchronous abort of the current lane
//   bypass      : lane bypass, sampled with slice 0
//   in_valid    : input slice valid
//   in_ready    : engine accepts an input slice
//   in_slice    : input slice, bit 5*y + x
//   out_valid   : output slice valid
//   out_ready   : downstream accepts the output slice
//   out_slice   : theta-mixed slice
//   out_z       : slice index of out_slice
//   out_last    : final beat of the lane (slice 0)
//   busy        : lane in progress or output pending
// ----------------------------------------------------------------------------
module theta_lane_engine
   import keccak_pkg::*;
#(
   parameter  int LANE_W = 64,
   localparam int ZW     = (LANE_W > 1) ? $clog2(LANE_W) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               bypass,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SLICE_W-1:0] in_slice,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SLICE_W-1:0] out_slice,
   output logic [ZW-1:0]      out_z,
   output logic               out_last,
   output logic               busy
);

   localparam logic [ZW-1:0] LAST_Z = ZW'(LANE_W - 1);

   state_t             state_q;
   logic [ZW-1:0]      z_cnt_q;
   logic [NCOL-1:0]    prev_par_q;
   logic [NCOL-1:0]    first_par_q;
   logic [SLICE_W-1:0] first_reg_q;
   logic               lane_byp_q;
   logic               out_valid_q;
   logic [SLICE_W-1:0] out_slice_q;
   logic [ZW-1:0]      out_z_q;
   logic               out_last_q;

   logic [NCOL-1:0]    in_par;
   logic [NCOL-1:0]    fr_par;
   logic [NCOL-1:0]    flush_prev;
   logic [SLICE_W-1:0] stream_mix;
   logic [SLICE_W-1:0] flush_mix;
   logic               out_free;
   logic               accept;

   slice_parity u_in_par (
      .slice_i (in_slice),
      .par_o   (in_par)
   );

   slice_parity u_first_par (
      .slice_i (first_reg_q),
      .par_o   (fr_par)
   );

   // A one-slice lane wraps onto itself: slice 0 is its own predecessor.
   assign flush_prev = (LANE_W == 1) ? fr_par : prev_par_q;

   assign stream_mix = theta_mix(in_slice, in_par, prev_par_q, lane_byp_q);
   assign flush_mix  = theta_mix(first_reg_q, first_par_q, flush_prev, lane_byp_q);

   // Single output register with no skid buffer: it is free when empty or
   // draining in this same cycle.
   assign out_free = !out_valid_q || out_ready;
   assign in_ready = (state_q != S_FLUSH) && out_free;
   assign accept   = in_valid && in_ready;

   // NOTE: every register here is updated with non-blocking assignments so
   // all next-state values are computed from the pre-edge state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_FIRST;
         z_cnt_q     <= '0;
         prev_par_q  <= '0;
         first_par_q <= '0;
         first_reg_q <= '0;
         lane_byp_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_slice_q <= '0;
         out_z_q     <= '0;
         out_last_q  <= 1'b0;
      end else if (clr) begin
         // Abort wins over any handshake in the same cycle.
         state_q     <= S_FIRST;
         z_cnt_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
         case (state_q)
            S_FIRST: begin
               if (accept) begin
                  first_reg_q <= in_slice;
                  first_par_q <= in_par;
                  prev_par_q  <= in_par;
                  lane_byp_q  <= bypass;
                  z_cnt_q     <= ZW'(1);
                  state_q     <= (LANE_W == 1) ? S_FLUSH : S_STREAM;
               end
            end
            S_STREAM: begin
               if (accept) begin
                  out_slice_q <= stream_mix;
                  out_z_q     <= z_cnt_q;
                  out_last_q  <= 1'b0;
                  out_valid_q <= 1'b1;
                  prev_par_q  <= in_par;
                  if (z_cnt_q == LAST_Z) begin
                     z_cnt_q <= '0;
                     state_q <= S_FLUSH;
                  end else begin
                     z_cnt_q <= z_cnt_q + ZW'(1);
                  end
               end
            end
            S_FLUSH: begin
               if (out_free) begin
                  out_slice_q <= flush_mix;
                  out_z_q     <= '0;
                  out_last_q  <= 1'b1;
                  out_valid_q <= 1'b1;
                  z_cnt_q     <= '0;
                  state_q     <= S_FIRST;
               end
            end
            default: begin
               state_q <= S_FIRST;
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_slice = out_slice_q;
   assign out_z     = out_z_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != S_FIRST) || out_valid_q;

endmodule

// File: tb/tb_theta_lane_engine.sv
// ----------------------------------------------------------------------------
// tb_theta_lane_engine
// Scoreboard bench for theta_lane_engine with LANE_W = 4. Stimulus pushes the
// expected output beats (order z = 1, 2, 3, 0) into a queue; a monitor pops
// and compares on every output handshake.
// ----------------------------------------------------------------------------
module tb_theta_lane_engine;

   localparam int LW = 4;

   typedef struct packed {
      logic [24:0] s;
      logic [1:0]  z;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic        bypass;
   logic        in_valid;
   logic        in_ready;
   logic [24:0] in_slice;
   logic        out_valid;
   logic        out_ready;
   logic [24:0] out_slice;
   logic [1:0]  out_z;
   logic        out_last;
   logic        busy;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          last_cyc = 0;
   int          c0;
   logic [24:0] lane_in  [LW];
   logic        lane_byp [LW];
   logic [24:0] exp_z1;

   theta_lane_engine #(.LANE_W(LW)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .bypass    (bypass),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_slice  (in_slice),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_slice (out_slice),
      .out_z     (out_z),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Column parity of a slice, computed bit by bit.
   function automatic logic [4:0] col_par(input logic [24:0] s);
      logic [4:0] p;
      p = '0;
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++)
            p[3'(x)] = p[3'(x)] ^ s[5'(5 * y + x)];
      return p;
   endfunction

   // Reference theta result for slice z of lane_in.
   function automatic logic [24:0] model_out(input int z, input logic byp);
      logic [4:0]  cz;
      logic [4:0]  cp;
      logic [24:0] r;
      cz = col_par(lane_in[z]);
      cp = col_par(lane_in[(z + LW - 1) % LW]);
      r  = lane_in[z];
      if (!byp)
         for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
               r[5'(5 * y + x)] = r[5'(5 * y + x)] ^ cz[3'((x + 4) % 5)] ^ cp[3'((x + 1) % 5)];
      return r;
   endfunction

   task automatic push(input logic [24:0] s, input int z, input logic last);
      exp_t e;
      e.s    = s;
      e.z    = 2'(z);
      e.last = last;
      exp_q.push_back(e);
   endtask

   // Expected beats for the first n outputs of lane_in, in emission order.
   task automatic push_model(input logic byp, input int n);
      for (int k = 0; k < n; k++) begin
         int z;
         z = (k < LW - 1) ? k + 1 : 0;
         push(model_out(z, byp), z, z == 0);
      end
   endtask

   task automatic send(input logic [24:0] s, input logic b);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_slice = s;
      bypass   = b;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_lane(input int n);
      @(posedge clk);
      #1;
      for (int z = 0; z < n; z++) send(lane_in[z], lane_byp[z]);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic random_lane();
      for (int z = 0; z < LW; z++) begin
         lane_in[z]  = 25'($urandom);
         lane_byp[z] = 1'b0;
      end
   endtask

   // Scoreboard monitor: compare on every completed output handshake.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got z=%0d slice=0x%0h, expected none", out_z, out_slice);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_slice", 32'(out_slice), 32'(mon_e.s));
            check("out_z", 32'(out_z), 32'(mon_e.z));
            check("out_last", 32'(out_last), 32'(mon_e.last));
            if (out_last) last_cyc <= cyc;
         end
      end
   end

   initial begin
      rst       = 1'b0;
      clr       = 1'b0;
      bypass    = 1'b0;
      in_valid  = 1'b0;
      in_slice  = '0;
      out_ready = 1'b1;

      // Reset state
      #3;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_slice", 32'(out_slice), 32'd0);
      check("rst_out_z", 32'(out_z), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      #9;
      rst = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Lane of zeros, lane throughput of LW+1 cycles
      for (int z = 0; z < LW; z++) begin
         lane_in[z]  = '0;
         lane_byp[z] = 1'b0;
      end
      push(25'h0000000, 1, 1'b0);
      push(25'h0000000, 2, 1'b0);
      push(25'h0000000, 3, 1'b0);
      push(25'h0000000, 0, 1'b1);
      @(posedge clk);
      #1;
      c0 = cyc;
      for (int z = 0; z < LW; z++) send(lane_in[z], 1'b0);
      wait_drain();
      check("zero_lane_cycles", 32'(last_cyc - c0), 32'd5);

      // Single bit in slice 0
      lane_in[0] = 25'h0000001;
      push(25'h1084210, 1, 1'b0);
      push(25'h0000000, 2, 1'b0);
      push(25'h0000000, 3, 1'b0);
      push(25'h0210843, 0, 1'b1);
      send_lane(LW);
      wait_drain();

      // Single bit in slice 3: parity wraps onto slice 0
      lane_in[0] = 25'h0000000;
      lane_in[3] = 25'h0000001;
      push(25'h0000000, 1, 1'b0);
      push(25'h0000000, 2, 1'b0);
      push(25'h0210843, 3, 1'b0);
      push(25'h1084210, 0, 1'b1);
      send_lane(LW);
      wait_drain();

      // Random lane with 3 cycles of backpressure after z=1 is presented
      random_lane();
      push_model(1'b0, LW);
      exp_z1 = model_out(1, 1'b0);
      fork
         send_lane(LW);
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("stall_in_ready", 32'(in_ready), 32'd0);
               check("stall_out_valid", 32'(out_valid), 32'd1);
               check("stall_out_slice", 32'(out_slice), 32'(exp_z1));
               check("stall_out_z", 32'(out_z), 32'd1);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_drain();

      // Bypass lane; bypass dropped mid-lane must be ignored
      random_lane();
      lane_byp[0] = 1'b1;
      lane_byp[1] = 1'b1;
      lane_byp[2] = 1'b0;
      lane_byp[3] = 1'b0;
      push(lane_in[1], 1, 1'b0);
      push(lane_in[2], 2, 1'b0);
      push(lane_in[3], 3, 1'b0);
      push(lane_in[0], 0, 1'b1);
      send_lane(LW);
      wait_drain();

      // Asynchronous reset after slice 2, then a full lane
      random_lane();
      push_model(1'b0, 2);
      send_lane(3);
      wait_drain();
      #2;
      rst = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_out_slice", 32'(out_slice), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      random_lane();
      push_model(1'b0, LW);
      send_lane(LW);
      wait_drain();

      // Synchronous clear after slice 2, then a full lane
      random_lane();
      push_model(1'b0, 2);
      send_lane(3);
      wait_drain();
      #2;
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      check("clr_out_valid", 32'(out_valid), 32'd0);
      check("clr_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("clr_in_ready", 32'(in_ready), 32'd1);
      random_lane();
      push_model(1'b0, LW);
      send_lane(LW);
      wait_drain();

      repeat (3) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      check("final_busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/theta_lane_engine.md
# theta_lane_engine

Parametrised Keccak theta step operating slice-serially: one 25-bit slice (bit 5·y + x) enters per beat, and the theta-mixed slice leaves per beat over a ready/valid pair. Column parity wraps correctly across the lane (slice 0 uses the parity of slice LANE_W-1). Lane length is configurable, and a per-lane bypass mode passes data through unmodified. It sits between the slice-serial state memory and the rho/pi stages of the permutation datapath.

## Interface
- LANE_W, 64, slices per lane (1..64); w = 2^l
- ZW, $clog2(LANE_W) min 1, derived; width of slice index
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- clr  in  1  synchronous abort; drops the partial lane and returns to S_FIRST
- bypass  in  1  sampled with slice 0; lane passes through unmodified
- in_valid  in  1  input slice valid
- in_ready  out  1  engine accepts input slice
- in_slice  in  25  input slice, bit 5·y + x
- out_valid  out  1  output slice valid
- out_ready  in  1  downstream accepts output
- out_slice  out  25  theta-mixed slice
- out_z  out  ZW  slice index of out_slice
- out_last  out  1  final beat of lane (always slice z = 0)
- busy  out  1  lane in progress (state != S_FIRST or out_valid)

## Operation
- C[x][z] = XOR over y of slice_z bit(5y+x); D[x][z] = C[(x+4)%5][z] ^ C[(x+1)%5][(z-1) mod LANE_W]; out bit(5y+x) = in bit(5y+x) ^ D[x][z]; D forced to 0 when the lane's bypass is set.
- Input slices arrive in order z = 0..LANE_W-1; slice index is counted internally, with no input tag.
- Emission order: z = 1, 2, …, LANE_W-1, then 0 (out_last=1). Slice 0 cannot be finished until C[·][LANE_W-1] is known.
- FSM:
  - S_FIRST: on accept, store raw slice 0 in first_reg, C0 in first_par and in prev_par, latch bypass into lane_byp; z_cnt ← 1; next S_STREAM, or S_FLUSH if LANE_W = 1. No output is produced.
  - S_STREAM: on accept of slice z, load the output register with the mixed slice, out_z = z, using prev_par; prev_par ← C[z]; when z = LANE_W-1, next S_FLUSH.
  - S_FLUSH: in_ready = 0; when the output register is free, load first_reg ^ D computed with first_par and prev_par, out_z = 0, out_last = 1; next S_FIRST.
- LANE_W = 1: slice 0 uses its own parity for both terms.
- clr: clears out_valid and z_cnt and returns to S_FIRST in the same edge; clr has priority over any accept.

## Timing
- Reset (rst low, asynchronous): S_FIRST, z_cnt = 0, out_valid = 0, out_slice = 0, out_z = 0, out_last = 0, busy = 0, all parity/first registers 0. in_ready is 1 once rst is high.
- Single output register (no skid): in_ready = (state != S_FLUSH) && (!out_valid || out_ready). Accept occurs on in_valid && in_ready at the rising edge.
- Latency: slice z (z ≥ 1) appears on out_* the cycle after acceptance. Slice 0 appears one cycle after slice LANE_W-1 leaves the register, or in the same edge that slice LANE_W-1 drains.
- Throughput: LANE_W + 1 cycles per lane with no backpressure; the next lane's slice 0 may be accepted the cycle out_last is loaded.
- While out_valid && !out_ready, out_slice/out_z/out_last are held stable.
- A bypass change mid-lane is ignored.

## Structure
- keccak_pkg: SLICE_W = 25, NCOL = 5, bit_idx(x,y) function, state enum {S_FIRST, S_STREAM, S_FLUSH}.
- Sub-module slice_parity: 25-bit slice → 5-bit C vector; instantiated twice (input path, first_reg path).
- Top module holds the FSM, z_cnt, prev_par/first_par/first_reg, and the output register.

## Test plan
- LANE_W=4, four all-zero slices, out_ready=1 → outputs z=1,2,3,0 all 0x0000000; out_last only on z=0; 5 cycles total.
- LANE_W=4, slice0 = 0x0000001, others 0 → z=1: 0x1084210, z=2: 0, z=3: 0, z=0: 0x0210843.
- LANE_W=4, slice3 = 0x0000001, others 0 → z=3: 0x0210843, z=0: 0x1084210, z=1,2: 0 (wrap-around).
- Random lane; out_ready low for 3 cycles mid-lane → in_ready low, outputs stable, results match the golden model with no loss or duplication.
- bypass=1 at slice 0 and toggled mid-lane → every out_slice equals its input; order is still 1..LANE_W-1, 0.
- rst asserted mid-lane (z=2), then clr tested the same way → outputs cleared immediately; a following full lane matches the golden model.
